// File: rtl/serial_tx_fifo.sv
// serial_tx_fifo: configurable UART transmitter with an input queue.
//   Frames are start(0), DATA_BITS data bits LSB first, optional parity,
//   then STOP_BITS stop bits (1). Characters are queued in a small FIFO so
//   the producer never has to wait on the transmitter.
// Ports:
//   clk       system clock, all state on the rising edge
//   rst_n     asynchronous active-low reset
//   tx        registered serial line, idle high
//   block_tx  high inhibits starting a new frame (registered once)
//   busy      registered: frame active, FIFO non-empty or block held
//   full      FIFO holds FIFO_DEPTH entries
//   level     current FIFO occupancy
//   overrun   one-cycle pulse after a write was dropped on a full FIFO
//   data      character to queue
//   new_data  write strobe, data sampled on the same edge
module serial_tx_fifo #(
  parameter int CLK_PER_BIT = 3,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  output logic                              tx,
  input  logic                              block_tx,
  output logic                              busy,
  output logic                              full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
  output logic                              overrun,
  input  logic [DATA_BITS-1:0]              data,
  input  logic                              new_data
);

  localparam int LVL_W    = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int STOP_LEN = STOP_BITS * CLK_PER_BIT;
  localparam int CTR_W    = $clog2(STOP_LEN);
  localparam int BIT_W    = $clog2(DATA_BITS);

  localparam logic [CTR_W-1:0] BIT_LAST  = CTR_W'(CLK_PER_BIT - 1);
  localparam logic [CTR_W-1:0] STOP_LAST = CTR_W'(STOP_LEN - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);

  // Reject illegal configurations at elaboration.
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("serial_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (CLK_PER_BIT < 2) begin : g_bad_cpb
    $error("serial_tx_fifo: CLK_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("serial_tx_fifo: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("serial_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("serial_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_q, state_d;
  logic [CTR_W-1:0]     ctr_q, ctr_d;
  logic [BIT_W-1:0]     bit_ctr_q, bit_ctr_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 block_q;
  logic                 overrun_q, overrun_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] head;
  logic                 head_par;
  logic                 full_int, push, pop, can_start;

  assign head      = mem[rd_ptr_q];
  // Even parity is the plain XOR; odd parity inverts it.
  assign head_par  = (^head) ^ (PARITY == 1);
  assign full_int  = (level_q == FULL_LVL);
  assign push      = new_data & ~full_int;
  assign can_start = (level_q != '0) & ~block_q;

  // Frame sequencer. A pop happens on every edge that enters START, which
  // is either leaving IDLE or chaining straight out of the last stop bit.
  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    bit_ctr_d = bit_ctr_q;
    shift_d   = shift_q;
    par_d     = par_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (can_start) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = head_par;
          ctr_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (ctr_q == BIT_LAST) begin
          ctr_d     = '0;
          bit_ctr_d = '0;
          state_d   = S_DATA;
        end else begin
          ctr_d = ctr_q + CTR_W'(1);
        end
      end
      S_DATA: begin
        if (ctr_q == BIT_LAST) begin
          ctr_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_ctr_q == DATA_LAST) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_ctr_d = bit_ctr_q + BIT_W'(1);
          end
        end else begin
          ctr_d = ctr_q + CTR_W'(1);
        end
      end
      S_PARITY: begin
        if (ctr_q == BIT_LAST) begin
          ctr_d   = '0;
          state_d = S_STOP;
        end else begin
          ctr_d = ctr_q + CTR_W'(1);
        end
      end
      S_STOP: begin
        if (ctr_q == STOP_LAST) begin
          ctr_d = '0;
          if (can_start) begin
            pop     = 1'b1;
            shift_d = head;
            par_d   = head_par;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          ctr_d = ctr_q + CTR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // tx is loaded from the next-state view so the start bit appears on the
  // same edge as the pop.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  // FIFO bookkeeping; pointers wrap naturally since depth is a power of two.
  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d   = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end
    overrun_d = new_data & full_int;
    busy_d    = !((state_q == S_IDLE) && (level_q == '0) && !block_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ctr_q     <= '0;
      bit_ctr_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      block_q   <= 1'b0;
      overrun_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      bit_ctr_q <= bit_ctr_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      block_q   <= block_tx;
      overrun_q <= overrun_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by level_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= data;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign full    = full_int;
  assign level   = level_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Testbench for serial_tx_fifo: an 8E1 instance (4 clk/bit) is checked by a
// cycle-exact frame monitor fed from a scoreboard queue; a 7O2 instance
// covers odd parity and two stop bits.
module tb_serial_tx_fifo;

  localparam int CPB  = 4;
  localparam int FLEN = 11 * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx, busy, full, overrun;
  logic       block_tx;
  logic [2:0] level;
  logic [7:0] data;
  logic       new_data;

  logic       tx2, busy2, full2, overrun2;
  logic       block_tx2;
  logic [2:0] level2;
  logic [6:0] data2;
  logic       new_data2;

  serial_tx_fifo #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .tx(tx), .block_tx(block_tx), .busy(busy),
    .full(full), .level(level), .overrun(overrun), .data(data),
    .new_data(new_data));

  serial_tx_fifo #(.CLK_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .tx(tx2), .block_tx(block_tx2), .busy(busy2),
    .full(full2), .level(level2), .overrun(overrun2), .data(data2),
    .new_data(new_data2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Wire-order 8E1 frame, bit 0 = start bit.
  function automatic logic [10:0] model(input logic [7:0] d);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) p = p ^ d[i];
    return {1'b1, p, d, 1'b0};
  endfunction

  // Monitor / scoreboard for u_dut.
  logic [7:0]  exp_q [$];
  logic [10:0] cap_q [$];
  logic        mon_active = 1'b0;
  int          mon_k = 0, mon_err = 0;
  int          frames_done = 0, b2b = 0;
  int          last_start = 0, last_end = -10;
  logic [10:0] mon_exp, mon_bits;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_active = 1'b0;
      end else begin
        if (!mon_active && tx === 1'b0) begin
          check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
          mon_exp    = (exp_q.size() > 0) ? model(exp_q.pop_front()) : 11'h0;
          mon_active = 1'b1;
          mon_k      = 0;
          mon_err    = 0;
          mon_bits   = '0;
          if (cyc == last_end + 1) b2b++;
          last_start = cyc;
        end
        if (mon_active) begin
          if (tx !== mon_exp[mon_k / CPB]) mon_err++;
          if (mon_k % CPB == CPB / 2) mon_bits[mon_k / CPB] = tx;
          if (mon_k == FLEN - 1) begin
            check("frame_cycle_exact", 32'(mon_err), 32'd0);
            cap_q.push_back(mon_bits);
            last_end    = cyc;
            frames_done = frames_done + 1;
            mon_active  = 1'b0;
          end else begin
            mon_k++;
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic write_char(input logic [7:0] d);
    data     = d;
    new_data = 1'b1;
    step();
    new_data = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int i;
    i = 0;
    while (frames_done < n && i < budget) begin
      step();
      i++;
    end
    check(name, 32'(frames_done >= n), 32'd1);
  endtask

  typedef struct {
    logic [7:0]  d;
    logic [10:0] frame;
  } vec_t;

  vec_t        vecs [6];
  logic [10:0] cap;
  logic [10:0] exp2;
  int          wcyc, rcyc, n0, err, b0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 11'b1_0_10100101_0};
    vecs[1] = '{8'h00, 11'b1_0_00000000_0};
    vecs[2] = '{8'hFF, 11'b1_0_11111111_0};
    vecs[3] = '{8'h01, 11'b1_1_00000001_0};
    vecs[4] = '{8'h80, 11'b1_1_10000000_0};
    vecs[5] = '{8'h3C, 11'b1_0_00111100_0};

    rst_n = 1'b0; block_tx = 1'b0; data = '0; new_data = 1'b0;
    block_tx2 = 1'b0; data2 = '0; new_data2 = 1'b0;
    repeat (3) step();
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_full", 32'(full), 32'd0);
    check("reset_level", 32'(level), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset2_flags", {29'd0, full2, overrun2, tx2}, 32'd1);
    rst_n = 1'b1;
    step();

    // 7O2 frame for 0x07: start, 1110000, parity 0, stop, stop.
    exp2 = 11'b11_0_0000111_0;
    data2 = 7'h07; new_data2 = 1'b1;
    step();
    new_data2 = 1'b0;
    wcyc = cyc;
    for (int i = 0; i < 10 && tx2 !== 1'b0; i++) step();
    check("odd_latency", 32'(cyc - wcyc), 32'd1);
    err = 0;
    for (int k = 0; k < FLEN; k++) begin
      if (tx2 !== exp2[k / CPB]) err++;
      step();
    end
    check("odd_frame_cycle_exact", 32'(err), 32'd0);
    check("odd_idle_after", 32'(tx2), 32'd1);
    repeat (3) step();
    check("odd_busy_done", 32'(busy2), 32'd0);

    // Table of single characters on the 8E1 instance.
    cap_q.delete();
    foreach (vecs[v]) begin
      n0 = frames_done;
      exp_q.push_back(vecs[v].d);
      write_char(vecs[v].d);
      wcyc = cyc;
      step();
      check("vec_busy", 32'(busy), 32'd1);
      wait_frames(n0 + 1, FLEN + 20, "vec_done");
      check("vec_latency", 32'(last_start - wcyc), 32'd1);
      cap = (cap_q.size() > 0) ? cap_q.pop_front() : 11'bx;
      check("vec_frame", 32'(cap), 32'(vecs[v].frame));
      repeat (3) step();
      check("vec_busy_idle", 32'(busy), 32'd0);
    end

    // Fill while blocked, overflow once, then drain back-to-back.
    block_tx = 1'b1;
    repeat (2) step();
    n0 = frames_done;
    for (int i = 0; i < 5; i++) begin
      data = 8'h11 * 8'(i + 1);
      if (i < 4) exp_q.push_back(data);
      new_data = 1'b1;
      step();
      if (i == 3) begin
        check("fill_full", 32'(full), 32'd1);
        check("fill_level", 32'(level), 32'd4);
        check("fill_no_overrun", 32'(overrun), 32'd0);
      end
      if (i == 4) begin
        check("drop_overrun", 32'(overrun), 32'd1);
        check("drop_level", 32'(level), 32'd4);
      end
    end
    new_data = 1'b0;
    step();
    check("overrun_one_cycle", 32'(overrun), 32'd0);
    err = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx !== 1'b1 || busy !== 1'b1 || frames_done != n0 || mon_active) err++;
      step();
    end
    check("blocked_no_start", 32'(err), 32'd0);
    b0 = b2b;
    block_tx = 1'b0;
    wait_frames(n0 + 4, 4 * FLEN + 20, "drain_done");
    check("drain_back_to_back", 32'(b2b - b0), 32'd3);
    check("drain_level", 32'(level), 32'd0);
    repeat (3) step();

    // block_tx raised mid-frame: frame completes, next waits for release.
    n0 = frames_done;
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h5E);
    write_char(8'hC3);
    write_char(8'h5E);
    for (int i = 0; i < 100 && !(mon_active && mon_k >= 20); i++) step();
    block_tx = 1'b1;
    wait_frames(n0 + 1, FLEN + 20, "midblock_first");
    err = 0;
    for (int i = 0; i < 30; i++) begin
      if (tx !== 1'b1 || busy !== 1'b1 || frames_done != n0 + 1 || mon_active) err++;
      step();
    end
    check("midblock_hold", 32'(err), 32'd0);
    block_tx = 1'b0;
    rcyc = cyc;
    wait_frames(n0 + 2, FLEN + 20, "midblock_second");
    check("release_latency", 32'(last_start - rcyc), 32'd2);
    repeat (3) step();

    // Asynchronous reset in the middle of the data bits.
    exp_q.push_back(8'h96);
    write_char(8'h96);
    for (int i = 0; i < 100 && !(mon_active && mon_k >= 14); i++) step();
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_tx", 32'(tx), 32'd1);
    check("async_rst_level", 32'(level), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    n0 = frames_done;
    cap_q.delete();
    exp_q.push_back(8'h5A);
    write_char(8'h5A);
    wait_frames(n0 + 1, FLEN + 20, "post_rst_done");
    cap = (cap_q.size() > 0) ? cap_q.pop_front() : 11'bx;
    check("post_rst_frame", 32'(cap), 32'(11'b1_0_01011010_0));
    repeat (3) step();

    // Write coinciding with a pop at level 2.
    block_tx = 1'b1;
    repeat (2) step();
    n0 = frames_done;
    exp_q.push_back(8'h21);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h84);
    write_char(8'h21);
    write_char(8'h42);
    block_tx = 1'b0;
    step();
    check("pre_pop_level", 32'(level), 32'd2);
    data = 8'h84;
    new_data = 1'b1;
    step();
    new_data = 1'b0;
    check("push_pop_level", 32'(level), 32'd2);
    check("push_pop_started", 32'(tx), 32'd0);
    wait_frames(n0 + 3, 3 * FLEN + 20, "push_pop_done");
    repeat (3) step();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("final_idle", {29'd0, busy, level2 != 3'd0, tx}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
